pll_lock_monitor: RTL and testbench
===================================

PLL_LOCK_MONITOR -- requirements
Module: pll_lock_monitor

Interface
REQ-001 SHALL have parameter N_CH, default 2: number of monitored PLL lock inputs, range 1..8.
REQ-002 SHALL have parameter STABLE_CYC, default 64: consecutive synced-high cycles needed to qualify lock, range 2..65535.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 4096: cycles allowed in WAIT before the timeout flag sets, range 2..2^20.
REQ-004 SHALL have parameter CNT_W, default 4: width of each per-channel loss counter.
REQ-005 SHALL have port clk, input, 1: single clock for all logic.
REQ-006 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-007 SHALL have port en, input, 1: monitor enable.
REQ-008 SHALL have port clr, input, 1: synchronous clear of counters and sticky flags.
REQ-009 SHALL have port pll_lock, input, N_CH: raw lock inputs, asynchronous to clk.
REQ-010 SHALL have port lock_stable, output, N_CH: qualified lock per channel.
REQ-011 SHALL have port loss_pulse, output, N_CH: one-cycle pulse per lock-loss event.
REQ-012 SHALL have port loss_cnt, output, N_CH*CNT_W: saturating loss counters; channel i occupies bits [i*CNT_W +: CNT_W].
REQ-013 SHALL have port timeout_err, output, N_CH: sticky flag, lock not qualified within TIMEOUT_CYC.
REQ-014 SHALL have port err_any, output, 1: OR of all timeout_err bits and all nonzero loss_cnt values.

Function
REQ-015 SHALL pass each pll_lock bit through a 2-flop synchronizer (sync1 -> sync2); the FSM uses only sync2.
REQ-016 SHALL run one independent FSM per channel with states WAIT, QUAL and LOCKED.
REQ-017 WAIT: a channel SHALL move to QUAL with its qualify counter at 0 when sync2=1 and en=1.
REQ-018 QUAL: the qualify counter SHALL increment each cycle sync2=1; on sync2=1 with counter==STABLE_CYC-1 the channel SHALL move to LOCKED.
REQ-019 QUAL: sync2=0 SHALL return the channel to WAIT with no loss_pulse and no loss_cnt change (glitch).
REQ-020 LOCKED: sync2=0 SHALL return the channel to WAIT, assert loss_pulse for exactly 1 cycle, and increment loss_cnt.
REQ-021 loss_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-022 lock_stable SHALL be registered and high only in LOCKED; it rises STABLE_CYC+2 edges after the first edge that samples pll_lock high, if pll_lock stays high.
REQ-023 The timeout counter SHALL increment each en=1 cycle in WAIT or QUAL, reset to 0 on entry to LOCKED, and hold its value otherwise.
REQ-024 When the timeout counter reaches TIMEOUT_CYC-1, timeout_err SHALL be set and stay set until clr or reset; the counter SHALL then stop.
REQ-025 en=0 SHALL force all FSMs to WAIT and zero the qualify and timeout counters, with no loss_pulse; loss_cnt and timeout_err SHALL hold.
REQ-026 Dropping en while in LOCKED SHALL NOT count as a loss event.
REQ-027 clr=1 SHALL zero all loss_cnt, timeout_err and timeout counters next cycle without affecting FSM state or lock_stable.
REQ-028 If clr and a loss event occur in the same cycle, clr SHALL win: loss_cnt=0, while loss_pulse still asserts.
REQ-029 err_any SHALL be registered, one cycle after its sources.

Reset
REQ-030 rst_n=0 SHALL asynchronously clear synchronizers, all counters, lock_stable, loss_pulse, loss_cnt, timeout_err and err_any to 0, and put every FSM in WAIT.
REQ-031 Deasserting rst_n mid-lock SHALL requalify from WAIT with no loss event counted.

Verification (N_CH=2, STABLE_CYC=8, TIMEOUT_CYC=100, CNT_W=4)
REQ-032 en=1, pll_lock[0] high at edge k and held -> lock_stable[0]=1 after edge k+10; loss_cnt=0.
REQ-033 pll_lock[1] pulses high for 5 cycles, then low -> lock_stable[1] never rises, loss_pulse[1] never asserts.
REQ-034 ch0 locked, pll_lock[0] dropped 17 times with requalify each time -> 17 one-cycle loss_pulse[0], loss_cnt[3:0]=15, err_any=1.
REQ-035 en=1, pll_lock[1]=0 for 100 cycles -> timeout_err[1]=1 and stays set; clr pulse -> timeout_err[1]=0 next cycle.
REQ-036 clr coincident with a loss on ch0 (loss_cnt=3) -> loss_pulse[0]=1, loss_cnt[3:0]=0.
REQ-037 rst_n low while both channels locked -> all outputs 0 immediately; after release, lock_stable requalifies in 10 cycles.

Source files
------------

// File: rtl/pll_lock_monitor.sv
// PLL lock monitor: synchronizes raw lock inputs, qualifies each channel's
// lock over a stable window, and counts lock losses. It also flags channels
// that do not lock within a timeout.
module pll_lock_monitor #(
    parameter int N_CH        = 2,
    parameter int STABLE_CYC  = 64,
    parameter int TIMEOUT_CYC = 4096,
    parameter int CNT_W       = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  clr,
    input  logic [N_CH-1:0]       pll_lock,
    output logic [N_CH-1:0]       lock_stable,
    output logic [N_CH-1:0]       loss_pulse,
    output logic [N_CH*CNT_W-1:0] loss_cnt,
    output logic [N_CH-1:0]       timeout_err,
    output logic                  err_any
);

    localparam int QW = $clog2(STABLE_CYC);
    localparam int TW = $clog2(TIMEOUT_CYC);

    localparam logic [QW-1:0] QUAL_LAST = QW'(STABLE_CYC - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] TO_ARM    = TW'(TIMEOUT_CYC - 2);

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_QUAL   = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    logic [N_CH-1:0] sync1_q;
    logic [N_CH-1:0] sync2_q;
    logic [N_CH-1:0] err_src;
    logic            err_any_q;

    // Two-flop synchronizer for the asynchronous lock inputs.
    // NOTE: clocked blocks use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= pll_lock;
            sync2_q <= sync1_q;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        state_e            state_q, state_d;
        logic [QW-1:0]     qual_cnt_q, qual_cnt_d;
        logic [TW-1:0]     to_cnt_q, to_cnt_d;
        logic              to_err_q, to_err_d;
        logic [CNT_W-1:0]  loss_cnt_q, loss_cnt_d;
        logic              lock_stable_q, lock_stable_d;
        logic              loss_pulse_q;
        logic              loss_evt;
        logic              lock_entry;

        // FSM state and qualify counter registers.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q    <= ST_WAIT;
                qual_cnt_q <= '0;
            end else begin
                state_q    <= state_d;
                qual_cnt_q <= qual_cnt_d;
            end
        end

        // Next-state logic: en low parks the channel in WAIT.
        // NOTE: every combinational output gets a default first so no latch is inferred.
        always_comb begin
            state_d    = state_q;
            qual_cnt_d = qual_cnt_q;
            if (!en) begin
                state_d    = ST_WAIT;
                qual_cnt_d = '0;
            end else begin
                case (state_q)
                    ST_WAIT: begin
                        if (sync2_q[i]) begin
                            state_d    = ST_QUAL;
                            qual_cnt_d = '0;
                        end
                    end
                    ST_QUAL: begin
                        if (!sync2_q[i]) begin
                            state_d    = ST_WAIT;
                            qual_cnt_d = '0;
                        end else if (qual_cnt_q == QUAL_LAST) begin
                            state_d    = ST_LOCKED;
                            qual_cnt_d = '0;
                        end else begin
                            qual_cnt_d = qual_cnt_q + QW'(1);
                        end
                    end
                    ST_LOCKED: begin
                        if (!sync2_q[i]) begin
                            state_d = ST_WAIT;
                        end
                    end
                    default: begin
                        state_d    = ST_WAIT;
                        qual_cnt_d = '0;
                    end
                endcase
            end
        end

        // Output logic: loss detection, timeout and loss counters; clr wins over counting.
        always_comb begin
            loss_evt      = en && (state_q == ST_LOCKED) && !sync2_q[i];
            lock_entry    = (state_d == ST_LOCKED) && (state_q != ST_LOCKED);
            lock_stable_d = (state_d == ST_LOCKED);
            to_cnt_d      = to_cnt_q;
            to_err_d      = to_err_q;
            loss_cnt_d    = loss_cnt_q;

            if (clr) begin
                to_cnt_d = '0;
                to_err_d = 1'b0;
            end else if (!en || lock_entry) begin
                to_cnt_d = '0;
            end else if ((state_q != ST_LOCKED) && (to_cnt_q != TO_LAST)) begin
                to_cnt_d = to_cnt_q + TW'(1);
                if (to_cnt_q == TO_ARM) begin
                    to_err_d = 1'b1;
                end
            end

            if (clr) begin
                loss_cnt_d = '0;
            end else if (loss_evt && (loss_cnt_q != '1)) begin
                loss_cnt_d = loss_cnt_q + CNT_W'(1);
            end
        end

        // Registered outputs and counters.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                to_cnt_q      <= '0;
                to_err_q      <= 1'b0;
                loss_cnt_q    <= '0;
                lock_stable_q <= 1'b0;
                loss_pulse_q  <= 1'b0;
            end else begin
                to_cnt_q      <= to_cnt_d;
                to_err_q      <= to_err_d;
                loss_cnt_q    <= loss_cnt_d;
                lock_stable_q <= lock_stable_d;
                loss_pulse_q  <= loss_evt;
            end
        end

        assign lock_stable[i]                 = lock_stable_q;
        assign loss_pulse[i]                  = loss_pulse_q;
        assign timeout_err[i]                 = to_err_q;
        assign loss_cnt[i*CNT_W +: CNT_W]     = loss_cnt_q;
        assign err_src[i]                     = to_err_q | (|loss_cnt_q);
    end

    // Summary error flag, registered one cycle behind its sources.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_any_q <= 1'b0;
        end else begin
            err_any_q <= |err_src;
        end
    end

    assign err_any = err_any_q;

endmodule

// File: tb/tb_pll_lock_monitor.sv
// Scoreboard bench for pll_lock_monitor: stimulus schedules expected output
// values per cycle, a monitor compares them on the falling edge.
module tb_pll_lock_monitor;

    localparam int N_CH        = 2;
    localparam int STABLE_CYC  = 8;
    localparam int TIMEOUT_CYC = 100;
    localparam int CNT_W       = 4;

    localparam int S_LOCK = 0;
    localparam int S_LOSS = 1;
    localparam int S_CNT  = 2;
    localparam int S_TO   = 3;
    localparam int S_ERR  = 4;
    localparam int S_HI0  = 5;
    localparam int S_RISE0 = 6;
    localparam int S_HI1  = 7;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  en;
    logic                  clr;
    logic [N_CH-1:0]       pll_lock;
    logic [N_CH-1:0]       lock_stable;
    logic [N_CH-1:0]       loss_pulse;
    logic [N_CH*CNT_W-1:0] loss_cnt;
    logic [N_CH-1:0]       timeout_err;
    logic                  err_any;

    int   cyc     = 0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   hi0     = 0;
    int   rise0   = 0;
    int   hi1     = 0;
    logic prev0   = 1'b0;

    typedef struct {
        int          cyc;
        int          sel;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sb_q[$];

    pll_lock_monitor #(
        .N_CH       (N_CH),
        .STABLE_CYC (STABLE_CYC),
        .TIMEOUT_CYC(TIMEOUT_CYC),
        .CNT_W      (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .clr        (clr),
        .pll_lock   (pll_lock),
        .lock_stable(lock_stable),
        .loss_pulse (loss_pulse),
        .loss_cnt   (loss_cnt),
        .timeout_err(timeout_err),
        .err_any    (err_any)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] actual(input int sel);
        case (sel)
            S_LOCK:  return 32'(lock_stable);
            S_LOSS:  return 32'(loss_pulse);
            S_CNT:   return 32'(loss_cnt);
            S_TO:    return 32'(timeout_err);
            S_ERR:   return 32'(err_any);
            S_HI0:   return 32'(hi0);
            S_RISE0: return 32'(rise0);
            S_HI1:   return 32'(hi1);
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Insert an expectation keeping the queue ordered by cycle.
    task automatic expect_at(input int c, input int sel, input logic [31:0] v, input string name);
        exp_t e;
        int   idx;
        e.cyc  = c;
        e.sel  = sel;
        e.exp  = v;
        e.name = name;
        idx    = sb_q.size();
        while (idx > 0 && sb_q[idx-1].cyc > c) idx--;
        sb_q.insert(idx, e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    // Drop ch0 lock for one cycle while ch1 stays locked, then requalify.
    task automatic drop(input bit with_clr, input int exp_cnt);
        int d;
        d = cyc;
        expect_at(d + 2,  S_LOSS, 0, "loss_pulse_before");
        expect_at(d + 3,  S_LOSS, 1, "loss_pulse_ch0");
        expect_at(d + 4,  S_LOSS, 0, "loss_pulse_one_cycle");
        expect_at(d + 3,  S_CNT,  32'(exp_cnt), "loss_cnt_after_drop");
        expect_at(d + 11, S_LOCK, 2, "requal_not_yet");
        expect_at(d + 12, S_LOCK, 3, "requal_locked");
        pll_lock[0] = 1'b0;
        tick();
        pll_lock[0] = 1'b1;
        if (with_clr) begin
            tick();
            clr = 1'b1;
            tick();
            clr = 1'b0;
        end
        wait_until(d + 13);
    endtask

    // Monitor: tally loss pulses, then compare every expectation due this cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            hi0   += int'(loss_pulse[0]);
            hi1   += int'(loss_pulse[1]);
            rise0 += (loss_pulse[0] && !prev0) ? 1 : 0;
            prev0  = loss_pulse[0];
            while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
                e = sb_q.pop_front();
                if (e.cyc < cyc) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL %s: scheduled for cycle %0d, seen at %0d", e.name, e.cyc, cyc);
                end else begin
                    check(e.name, actual(e.sel), e.exp);
                end
            end
        end
    end

    initial begin
        int n, p, m, d, e, r, c;
        rst_n    = 1'b0;
        en       = 1'b0;
        clr      = 1'b0;
        pll_lock = '0;

        expect_at(2, S_LOCK, 0, "rst_lock_stable");
        expect_at(2, S_LOSS, 0, "rst_loss_pulse");
        expect_at(2, S_CNT,  0, "rst_loss_cnt");
        expect_at(2, S_TO,   0, "rst_timeout_err");
        expect_at(2, S_ERR,  0, "rst_err_any");
        wait_until(3);
        rst_n = 1'b1;
        tick();

        // ch0 lock held, ch1 high for only five cycles then low.
        n = cyc;
        en       = 1'b1;
        pll_lock = 2'b11;
        expect_at(n + 10, S_LOCK, 0, "lock_ch0_not_yet");
        expect_at(n + 11, S_LOCK, 1, "lock_ch0_qualified");
        expect_at(n + 11, S_CNT,  0, "lock_ch0_no_loss");
        expect_at(n + 50, S_LOCK, 1, "glitch_ch1_no_lock");
        expect_at(n + 98, S_TO,   0, "timeout_not_yet");
        expect_at(n + 99, S_TO,   2, "timeout_ch1_set");
        expect_at(n + 99, S_ERR,  0, "err_any_lags");
        expect_at(n + 100, S_ERR, 1, "err_any_timeout");
        expect_at(n + 104, S_TO,  2, "timeout_sticky");
        wait_until(n + 5);
        pll_lock[1] = 1'b0;

        // Lock ch1 late: timeout_err stays set until clr.
        wait_until(n + 105);
        p = cyc;
        pll_lock[1] = 1'b1;
        expect_at(p + 10, S_LOCK, 1, "lock_ch1_not_yet");
        expect_at(p + 11, S_LOCK, 3, "lock_ch1_qualified");
        expect_at(p + 11, S_TO,   2, "timeout_sticky_after_lock");
        wait_until(p + 12);
        m = cyc;
        expect_at(m + 1, S_TO,   0, "clr_timeout");
        expect_at(m + 1, S_LOCK, 3, "clr_keeps_lock");
        expect_at(m + 1, S_ERR,  1, "err_any_before_clr_seen");
        expect_at(m + 2, S_ERR,  0, "err_any_after_clr");
        clr = 1'b1;
        tick();
        clr = 1'b0;
        wait_until(m + 3);

        // Three losses, the first one also checking err_any latency.
        d = cyc;
        expect_at(d + 3, S_ERR, 0, "err_any_loss_lag");
        expect_at(d + 4, S_ERR, 1, "err_any_loss");
        for (int i = 1; i <= 3; i++) drop(1'b0, i);

        // Loss coincident with clr: counter cleared, pulse still seen.
        d = cyc;
        expect_at(d + 3, S_ERR, 1, "err_any_cnt3");
        expect_at(d + 4, S_ERR, 0, "err_any_clr_loss");
        drop(1'b1, 0);

        // Seventeen losses: counter saturates at 15.
        for (int i = 1; i <= 17; i++) drop(1'b0, (i > 15) ? 15 : i);
        expect_at(cyc + 1, S_ERR, 1, "err_any_saturated");
        expect_at(cyc + 1, S_CNT, 32'h0F, "loss_cnt_saturated");
        wait_until(cyc + 2);

        // Dropping en while locked is not a loss.
        e = cyc;
        en = 1'b0;
        expect_at(e + 1,  S_LOCK, 0, "en_off_unlock");
        expect_at(e + 1,  S_LOSS, 0, "en_off_no_pulse");
        expect_at(e + 1,  S_CNT,  32'h0F, "en_off_cnt_hold");
        expect_at(e + 1,  S_TO,   0, "en_off_timeout_hold");
        expect_at(e + 10, S_LOCK, 0, "en_on_not_yet");
        expect_at(e + 11, S_LOCK, 3, "en_on_relock");
        expect_at(e + 11, S_CNT,  32'h0F, "en_on_cnt_hold");
        tick();
        tick();
        en = 1'b1;
        wait_until(e + 12);

        // Asynchronous reset while both channels are locked.
        r = cyc;
        rst_n = 1'b0;
        expect_at(r, S_LOCK, 0, "async_rst_lock");
        expect_at(r, S_LOSS, 0, "async_rst_pulse");
        expect_at(r, S_CNT,  0, "async_rst_cnt");
        expect_at(r, S_TO,   0, "async_rst_timeout");
        expect_at(r, S_ERR,  0, "async_rst_err_any");
        expect_at(r + 12, S_LOCK, 0, "post_rst_not_yet");
        expect_at(r + 13, S_LOCK, 3, "post_rst_relock");
        expect_at(r + 13, S_CNT,  0, "post_rst_no_loss");
        expect_at(r + 13, S_ERR,  0, "post_rst_err_any");
        tick();
        tick();
        rst_n = 1'b1;
        wait_until(r + 14);

        // Pulse totals: 21 single-cycle pulses on ch0, none on ch1.
        c = cyc;
        expect_at(c + 1, S_HI0,   21, "ch0_pulse_cycles");
        expect_at(c + 1, S_RISE0, 21, "ch0_pulse_events");
        expect_at(c + 1, S_HI1,   0,  "ch1_no_pulses");

        for (int k = 0; k < 20 && sb_q.size() > 0; k++) tick();
        while (sb_q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: never compared (due cycle %0d)", sb_q[0].name, sb_q[0].cyc);
            void'(sb_q.pop_front());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
